// File: rtl/btn_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | btn_pkg: arbiter state encoding and default timing constants.         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package btn_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_e;

  localparam int DB_CNT_DEFAULT     = 16;
  localparam int RPT_DELAY_DEFAULT  = 1000;
  localparam int RPT_PERIOD_DEFAULT = 250;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | btn_debounce: 2-flop sync, debounce counter, 1-cycle press event;     |
// | auto-repeat events when BTN_REPEAT_EN is defined.      Rev 1.0        |
// +-----------------------------------------------------------------------+
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DB_CNT     = DB_CNT_DEFAULT,
  parameter int RPT_DELAY  = RPT_DELAY_DEFAULT,
  parameter int RPT_PERIOD = RPT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic evt
);

  localparam int CW = $clog2(DB_CNT);

  logic          s0_q, s1_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise;

  // cnt holds the number of earlier consecutive cycles where s1 disagreed with stable
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s1_q != stable_q) begin
      if (cnt_q == CW'(DB_CNT - 1)) begin
        stable_d = s1_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Event is raised in the cycle before stable goes high so pending sets on the same edge
  assign rise = stable_d & ~stable_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s0_q     <= btn;
      s1_q     <= s0_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic [RW-1:0] rpt_q, rpt_d;
  logic          rpt_evt;

  // Down-counter: loaded on the press, fires at zero, then reloads with the period
  always_comb begin
    rpt_d   = '0;
    rpt_evt = 1'b0;
    if (rise) begin
      rpt_d = RW'(RPT_DELAY - 1);
    end else if (stable_q && stable_d) begin
      if (rpt_q == '0) begin
        rpt_evt = 1'b1;
        rpt_d   = RW'(RPT_PERIOD - 1);
      end else begin
        rpt_d = rpt_q - RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end

  assign evt = rise | rpt_evt;
`else
  logic unused_rpt;
  assign unused_rpt = ^{RPT_DELAY, RPT_PERIOD};
  assign evt        = rise;
`endif

endmodule
`default_nettype wire

// File: rtl/btn_cmd_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | btn_cmd_arbiter: N debounced buttons -> pending requests -> one       |
// | round-robin valid/ready command stream. Option: BTN_REPEAT_EN. Rev 1.0|
// +-----------------------------------------------------------------------+
module btn_cmd_arbiter
  import btn_pkg::*;
#(
  parameter int N          = 4,
  parameter int DB_CNT     = DB_CNT_DEFAULT,
  parameter int RPT_DELAY  = RPT_DELAY_DEFAULT,
  parameter int RPT_PERIOD = RPT_PERIOD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         btn,
  output logic                 cmd_valid,
  output logic [$clog2(N)-1:0] cmd_id,
  input  logic                 cmd_ready,
  output logic [N-1:0]         pending,
  output logic                 overflow
);

  localparam int IW = $clog2(N);

  logic [N-1:0] evt;

  for (genvar g = 0; g < N; g++) begin : g_chan
    btn_debounce #(
      .DB_CNT     (DB_CNT),
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn[g]),
      .evt   (evt[g])
    );
  end

  arb_state_e    state_q, state_d;
  logic [N-1:0]  pending_q, pending_d, clr;
  logic          overflow_q, overflow_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [IW-1:0] cmd_id_q, cmd_id_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] pick;
  logic [IW:0]   cand;
  logic          hs;

  assign hs = cmd_valid_q & cmd_ready;

  // A new event wins over a same-cycle clear and is not counted as an overflow
  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = hs && (cmd_id_q == IW'(i));
    end
    pending_d  = (pending_q & ~clr) | evt;
    overflow_d = |(evt & pending_q & ~clr);
  end

  // Scanning from the far end lets the candidate nearest rr_ptr be assigned last
  always_comb begin
    pick = rr_ptr_q;
    cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (IW + 1)'(i);
      if (cand >= (IW + 1)'(N)) begin
        cand = cand - (IW + 1)'(N);
      end
      if (pending_q[cand[IW-1:0]]) begin
        pick = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_id_d    = cmd_id_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (|pending_q) begin
          cmd_id_d    = pick;
          cmd_valid_d = 1'b1;
          state_d     = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        if (hs) begin
          cmd_valid_d = 1'b0;
          rr_ptr_d    = (cmd_id_q == IW'(N - 1)) ? '0 : cmd_id_q + IW'(1);
          state_d     = ARB_IDLE;
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_id_q    <= cmd_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_id    = cmd_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: doc/btn_cmd_arbiter.md
# btn_cmd_arbiter

Turns N raw, bouncy pushbuttons into a single stream of one-shot button commands. Each channel synchronises, debounces and rising-edge-detects its button, then latches the edge as a pending request. A round-robin arbiter issues pending requests one at a time over a valid/ready handshake. It sits between the board buttons and the lab datapath controllers, such as push/pop/step control, and replaces ad-hoc per-button edge logic.

## Interface
One clock; reset is synchronous and active-low.

Parameters:
- N, default 4: number of button channels, 2..8.
- DB_CNT, default 16: consecutive stable cycles required to accept a level change, ≥2.
- RPT_DELAY, default 1000: cycles held before the first auto-repeat. Used only with BTN_REPEAT_EN.
- RPT_PERIOD, default 250: cycles between subsequent auto-repeats. Used only with BTN_REPEAT_EN.

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- rst_n, input, 1: synchronous active-low reset.
- btn, input, N: raw asynchronous button levels, active-high.
- cmd_valid, output, 1: a command is presented.
- cmd_id, output, $clog2(N): index of the presented channel.
- cmd_ready, input, 1: consumer accepts the command this cycle.
- pending, output, N: latched unserved requests, one bit per channel.
- overflow, output, 1: one-cycle pulse when an edge arrives on a channel whose pending bit is already set.

## Operation
- Reset, with rst_n low at a posedge, clears the following:
  - all sync flops, stable levels, debounce counters and pending bits;
  - rr_ptr (set to 0), cmd_valid, cmd_id and overflow;
  - repeat counters.
- Reset mid-handshake drops the presented command without a handshake.
- Sync stage: 2 flops per channel (s0, s1).
- Debounce: per-channel counter cnt with the following rules.
  - If s1 == stable, cnt is set to 0.
  - Otherwise cnt increments.
  - When cnt == DB_CNT-1 and s1 != stable, stable takes s1 and cnt is set to 0.
  - Glitches shorter than DB_CNT cycles never change stable.
- Edge: a channel generates an event in the cycle its stable flips 0→1. A falling flip generates nothing.
- Pending: an event sets the channel's pending bit.
  - If the bit is already set and is not being cleared this cycle, the event is dropped and overflow pulses for 1 cycle.
  - A simultaneous event and handshake-clear on the same bit leaves the bit set (set wins) and does not pulse overflow.
- Arbiter, 2 states:
  - IDLE: when pending != 0, choose the first set bit scanning rr_ptr, rr_ptr+1, … mod N. Register cmd_id = choice and cmd_valid = 1, then go to OFFER.
  - OFFER: cmd_valid and cmd_id are held stable until cmd_ready. On cmd_valid & cmd_ready:
    - clear pending[cmd_id];
    - set rr_ptr = (cmd_id+1) mod N;
    - set cmd_valid = 0;
    - return to IDLE.
  - The next command is offered no earlier than the cycle after a handshake, so throughput is ≤1 command per 2 cycles.
- cmd_ready while cmd_valid = 0 is ignored.

## Timing
- Idle channel, btn rising and held clean, with the first sampling posedge counted as edge 1:
  - s1 is high after edge 2;
  - stable and pending set at edge DB_CNT+2;
  - cmd_valid high after edge DB_CNT+3.
- Release is debounced identically (DB_CNT cycles) before a new press can be recognised.
- overflow is registered: it is high for exactly the cycle after the dropped event's edge.
- pending reflects its register value, which updates the same edge as the set or clear.

## Configuration
- BTN_REPEAT_EN defined:
  - While stable stays high, a per-channel repeat counter generates an additional event RPT_DELAY cycles after the press event.
  - It then generates another event every RPT_PERIOD cycles.
  - The counter clears when stable goes low.
  - Repeat events follow the same pending and overflow rules.
- BTN_REPEAT_EN undefined:
  - No repeat logic is present and RPT_* are unused.
  - A held button produces exactly one command.

## Structure
- Package btn_pkg holds the arbiter state enum (ARB_IDLE, ARB_OFFER) and the default constants for DB_CNT, RPT_DELAY and RPT_PERIOD.
- Sub-module btn_debounce, instantiated N times: sync, debounce counter, rising event and the optional repeat counter. Its output is a 1-cycle event pulse.
- The top level holds pending, overflow, rr_ptr and the arbiter.

## Test plan
- Reset: N=4, DB_CNT=4, rst_n low 2 cycles.
  - Required: all outputs 0, pending=0000.
  - Also drive rst_n low during OFFER: cmd_valid drops the next cycle.
- Single press: btn[2] rises at edge 1 and is held, cmd_ready=1.
  - Required: cmd_valid=1 with cmd_id=2 after edge 7.
  - Required: pending=0000 after the handshake edge.
  - Required: no second command while held (macro off).
- Bounce: btn[0] toggles with 3-cycle pulses for 20 cycles, then holds.
  - Required: exactly one command with cmd_id=0.
- Round robin: pending set on channels 0, 1 and 3 together, cmd_ready=1.
  - Required: commands issued in order 0, 1, 3.
  - Then re-press channel 0 during the channel-1 offer: the order continues 3, then 0.
- Overflow: cmd_ready=0, btn[1] pressed, released and pressed again.
  - Required: overflow pulses once and pending[1] stays 1.
  - Required: raising cmd_ready yields one cmd_id=1 command.
- Repeat (BTN_REPEAT_EN, RPT_DELAY=20, RPT_PERIOD=10): hold btn[3] for 60 cycles after acceptance.
  - Required: commands at press, +20 and +30, +40, +50.
  - Required: none after release.
